// File: rtl/counter_sched_pkg.sv
// Shared types and defaults for the counter interval scheduler.
// Holds the FSM state encoding and the default counter/requester sizes.
package counter_sched_pkg;

    localparam int WIDTH_D = 4;
    localparam int NREQ_D  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Index width for a requester number; never narrower than 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_sched_if.sv
// Requester-side bundle of the interval scheduler.
// master: requesters (drive req/start_val/end_val); slave: scheduler.
interface counter_sched_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] start_val;
    logic [NREQ*WIDTH-1:0] end_val;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;

    modport master (
        output req, start_val, end_val,
        input  gnt, done, busy
    );

    modport slave (
        input  req, start_val, end_val,
        output gnt, done, busy
    );
endinterface

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after i_ptr.
// Ports: i_req, i_ptr in; o_gnt one-hot, o_idx binary, o_any valid out.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDXW-1:0] o_idx,
    output logic            o_any
);

    always_comb begin
        int j;
        j     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(i_ptr) + k) % NREQ;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one loadable up-counter between requesters.
// Ports: clk, reset (sync, active-high), bus (slave), cnt_* counter drive/sense.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int NREQ  = NREQ_D
) (
    input  logic             clk,
    input  logic             reset,
    counter_sched_if.slave   bus,
    output logic             cnt_reset,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_data,
    input  logic [WIDTH-1:0] cnt_count
);

    localparam int IDXW = idx_w(NREQ);

    state_t            r_state;
    logic [IDXW-1:0]   r_owner;
    logic [IDXW-1:0]   r_ptr;
    logic [WIDTH-1:0]  r_start;
    logic [WIDTH-1:0]  r_end;

    logic [NREQ-1:0]   w_win_oh;
    logic [IDXW-1:0]   w_win_idx;
    logic              w_any;
    logic [IDXW-1:0]   w_next_ptr;
    logic              w_owner_req;
    logic [NREQ-1:0]   w_owner_oh;
    logic              w_granted;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_win_oh),
        .o_idx (w_win_idx),
        .o_any (w_any)
    );

    assign w_next_ptr  = (int'(w_win_idx) == NREQ - 1) ? '0
                                                       : w_win_idx + IDXW'(1);
    assign w_owner_req = bus.req[r_owner];
    assign w_owner_oh  = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_granted   = (r_state == S_LOAD) || (r_state == S_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_start <= '0;
            r_end   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_win_idx;
                        r_ptr   <= w_next_ptr;
                        r_start <= bus.start_val[int'(w_win_idx)*WIDTH +: WIDTH];
                        r_end   <= bus.end_val[int'(w_win_idx)*WIDTH +: WIDTH];
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state <= w_owner_req ? S_RUN : S_IDLE;
                end
                S_RUN: begin
                    // A withdrawn request wins over a coincident end match.
                    if (!w_owner_req) begin
                        r_state <= S_IDLE;
                    end else if (cnt_count == r_end) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Everything below decodes registered state only; req never reaches
    // an output combinationally.
    assign bus.gnt   = w_granted ? w_owner_oh : '0;
    assign bus.done  = (r_state == S_DONE) ? w_owner_oh : '0;
    assign bus.busy  = (r_state != S_IDLE);
    assign cnt_reset = (r_state == S_IDLE) || (r_state == S_DONE);
    assign cnt_load  = (r_state == S_LOAD);
    assign cnt_data  = (r_state == S_LOAD) ? r_start : '0;

    logic w_unused;
    assign w_unused = ^w_win_oh;

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Scheduler and sequencer for one shared loadable 4-bit up-counter: the counter has synchronous reset, load and data inputs, and increments every cycle when not loaded.
- Up to NREQ requesters each ask for one timed interval by supplying a start value and an end value.
- The block arbitrates round-robin between requesters, loads the counter with the winner's start value and watches the counter's output.
- When the count reaches the winner's end value, it pulses done to that requester and releases the counter.

Parameters:
- WIDTH, 4, counter width; must match the shared counter.
- NREQ, 2, number of requesters (2..8).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level; must be held until done or abort
- start_val  in  NREQ*WIDTH  flattened start values; requester i uses bits [i*WIDTH +: WIDTH]
- end_val  in  NREQ*WIDTH  flattened end values, same packing as start_val
- gnt  out  NREQ  one-hot grant; high during LOAD and RUN
- done  out  NREQ  one-hot, one-cycle completion pulse
- busy  out  1  high in LOAD, RUN and DONE
- cnt_reset  out  1  drives the counter's reset input
- cnt_load  out  1  drives the counter's load input
- cnt_data  out  WIDTH  drives the counter's data input
- cnt_count  in  WIDTH  the counter's count output

Behaviour:
- Reset:
  - state=IDLE, owner=0, rr pointer=0.
  - gnt=0, done=0, busy=0, cnt_load=0, cnt_data=0.
  - cnt_reset=1 (IDLE decode).
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cnt_reset=1.
  - If any req bit is set, pick the winner by round-robin starting at the pointer.
  - Latch owner, start_val[owner] and end_val[owner] into internal registers, then go to LOAD.
  - Pointer becomes (owner+1) mod NREQ.
  - If no req bit is set, stay in IDLE.
- LOAD (exactly 1 cycle):
  - cnt_load=1, cnt_data=latched start, cnt_reset=0, gnt[owner]=1.
  - Next state RUN; the counter holds start on the first RUN cycle.
- RUN:
  - cnt_load=0, cnt_reset=0, gnt[owner]=1.
  - When cnt_count == latched end, go to DONE.
  - Counting is modulo 2^WIDTH, so end < start wraps.
  - Number of RUN cycles is ((end - start) mod 2^WIDTH) + 1, range 1..16.
- DONE (exactly 1 cycle):
  - done[owner]=1, gnt=0, cnt_reset=1, then go to IDLE.
  - No arbitration happens in DONE, so the minimum gap between intervals is 2 cycles (DONE, IDLE).
- Latency: req rising in IDLE at cycle t gives gnt at t+1 and cnt_load at t+1; the first compare is at t+2.
- Abort:
  - If req[owner] drops during LOAD or RUN, go to IDLE next cycle.
  - No done pulse; gnt drops at the same edge.
  - The pointer has already advanced.
- Latched values: start_val and end_val changes after the IDLE latch are ignored.
- Non-owner req: lines may change freely; they are only sampled in IDLE.
- reset asserted in any state returns the block to IDLE at the next edge and suppresses any pending done.
- All outputs are pure decodes of registered state, owner and latched start; there is no combinational path from req to outputs.

Decomposition:
- Shared package:
  - state enum {IDLE, LOAD, RUN, DONE} (2-bit encoding)
  - default WIDTH and NREQ constants
- Sub-module rr_arbiter:
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner and binary index.
  - Purely combinational.
  - Instantiated once.

Test Plan:
- Reset, then idle: req=0 for 5 cycles -> gnt=0, done=0, busy=0, cnt_reset=1, cnt_load never 1.
- Single interval: req[0]=1, start0=3, end0=7 -> cnt_load for 1 cycle with cnt_data=3, 5 RUN cycles (count 3..7), done[0] pulses once, then gnt=0.
- Wrap and equality:
  - start=14, end=1 -> 4 RUN cycles (14, 15, 0, 1), then done.
  - start=end=9 -> 1 RUN cycle, then done.
- Round-robin: req=2'b11 held with intervals of length 2 -> grant order 0, 1, 0, 1; each done pulses on the matching bit; 2-cycle gap between intervals.
- Abort: req[1] dropped on the 3rd RUN cycle (start=0, end=15) -> gnt=0 next cycle, no done, IDLE; the next req[0] is granted immediately.
- Mid-run reset: reset pulsed during RUN -> next cycle state IDLE, gnt=0, done=0, cnt_reset=1, pointer=0.
